// File: rtl/reg_list_sequencer_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
package reg_list_sequencer_pkg;

    localparam int REG_COUNT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_list_sequencer_lsb.sv
// Isolates the lowest set bit of a 16-bit vector (x & -x); zero in gives zero out.
module lsb_isolate16 (
    input  logic [15:0] i_vec,
    output logic [15:0] o_lsb
);

    assign o_lsb = i_vec & (~i_vec + 16'd1);

endmodule

// File: rtl/reg_list_sequencer.sv
// Walks an LDM/STM register list in ascending order, issuing one transfer per
// accepted handshake with its byte offset; all outputs come straight from flops.
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
#(
    parameter int OFFSET_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] reg_list,
    input  logic        abort,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] onehot,
    output logic [5:0]  offset,
    output logic        last,
    output logic [4:0]  count,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    logic [15:0] r_remaining;
    logic [4:0]  r_step;
    logic [4:0]  r_count;
    logic        r_valid;
    logic [15:0] r_onehot;
    logic [5:0]  r_offset;
    logic        r_last;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [15:0] w_remaining_nxt;
    logic [4:0]  w_step_nxt;
    logic [4:0]  w_count_nxt;
    logic [4:0]  w_pop;
    logic [15:0] w_lsb_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_onehot_nxt;
    logic [5:0]  w_offset_nxt;
    logic        w_last_nxt;

    // The select for the next cycle is isolated from the next remaining set,
    // so onehot/last can be registered rather than decoded after the flops.
    lsb_isolate16 u_lsb (
        .i_vec (w_remaining_nxt),
        .o_lsb (w_lsb_nxt)
    );

    // Popcount of the incoming list, used only when a start is accepted.
    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < REG_COUNT; i++) begin
            w_pop = w_pop + {4'd0, reg_list[i]};
        end
    end

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_step_nxt      = r_step;
        w_count_nxt     = r_count;
        if (abort) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = 16'd0;
            w_step_nxt      = 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_remaining_nxt = reg_list;
                        w_count_nxt     = w_pop;
                        w_step_nxt      = 5'd0;
                        w_state_nxt     = (reg_list != 16'd0) ? RUN : DONE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RUN: begin
                    if (r_valid && ready) begin
                        w_remaining_nxt = r_remaining & ~r_onehot;
                        w_step_nxt      = r_step + 5'd1;
                        w_state_nxt     = r_last ? DONE : RUN;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                DONE: begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = 16'd0;
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = 16'd0;
                    w_step_nxt      = 5'd0;
                end
            endcase
        end

        w_valid_nxt = (w_state_nxt == RUN);
        if (w_valid_nxt) begin
            w_onehot_nxt = w_lsb_nxt;
            w_last_nxt   = (w_lsb_nxt == w_remaining_nxt);
            w_offset_nxt = 6'(w_step_nxt * OFFSET_STEP);
        end else begin
            w_onehot_nxt = 16'd0;
            w_last_nxt   = 1'b0;
            w_offset_nxt = 6'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= 16'd0;
            r_step      <= 5'd0;
            r_count     <= 5'd0;
            r_valid     <= 1'b0;
            r_onehot    <= 16'd0;
            r_offset    <= 6'd0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_step      <= w_step_nxt;
            r_count     <= w_count_nxt;
            r_valid     <= w_valid_nxt;
            r_onehot    <= w_onehot_nxt;
            r_offset    <= w_offset_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign valid  = r_valid;
    assign onehot = r_onehot;
    assign offset = r_offset;
    assign last   = r_last;
    assign count  = r_count;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
